// File: rtl/pe_pkg.sv
// Shared definitions for the pe_v3 processing element.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package pe_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } pe_state_e;

    // Widest accumulator the saturation helpers can describe.
    localparam int LIM_W = 64;

    // Multiply cycles per product: R multiplier bits retired each cycle.
    function automatic int pe_calc_m(input int d_w, input int r);
        return d_w / r;
    endfunction

    // Largest representable accumulator value, right-aligned in LIM_W bits.
    function automatic logic [LIM_W-1:0] pe_sat_hi(input int w, input bit sgn);
        logic [LIM_W-1:0] ones;
        ones = '1;
        return sgn ? (ones >> (LIM_W - w + 1)) : (ones >> (LIM_W - w));
    endfunction

    // Smallest representable accumulator value (two's complement when signed).
    function automatic logic [LIM_W-1:0] pe_sat_lo(input int w, input bit sgn);
        logic [LIM_W-1:0] one;
        one    = '0;
        one[0] = 1'b1;
        return sgn ? (one << (w - 1)) : '0;
    endfunction

endpackage

// File: rtl/pe_shift_add_mul_seq.sv
// Sequential shift-add multiplier retiring R multiplier bits per cycle.
// Latency: start accepted on an edge, done_o/prod_o valid during the M-th following cycle.
// Backpressure: none; start_i is ignored while a product is in flight.
// Ports: clk, rst (async active-low); start_i with a_i/b_i; done_o pulses with the final prod_o.
module pe_shift_add_mul_seq
    import pe_pkg::*;
#(
    parameter int D_W    = 8,
    parameter int R      = 2,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [D_W-1:0]   a_i,
    input  logic [D_W-1:0]   b_i,
    output logic             done_o,
    output logic [2*D_W-1:0] prod_o
);
    localparam int M     = pe_calc_m(D_W, R);
    localparam int P_W   = 2 * D_W;
    localparam int CNT_W = (M > 1) ? $clog2(M) : 1;
    localparam logic [CNT_W-1:0] M_LAST = CNT_W'(M - 1);
    localparam logic SGN = (SIGNED != 0);

    if (D_W % R != 0) begin : g_chk_r
        $error("pe_shift_add_mul_seq: D_W must be a multiple of R");
    end

    logic             run_q;
    logic [CNT_W-1:0] step_q;
    logic [P_W-1:0]   mcand_q;
    logic [D_W-1:0]   mplier_q;
    logic [P_W-1:0]   psum_q;
    logic             neg_q;

    logic             a_neg, b_neg;
    logic [D_W-1:0]   a_mag, b_mag;
    logic [P_W-1:0]   part;
    logic             last;

    // Signed operands are multiplied as magnitudes; -2^(D_W-1) still fits unsigned.
    always_comb begin
        a_neg = SGN & a_i[D_W-1];
        b_neg = SGN & b_i[D_W-1];
        a_mag = a_neg ? (~a_i + 1'b1) : a_i;
        b_mag = b_neg ? (~b_i + 1'b1) : b_i;
    end

    // R partial products of the already-shifted multiplicand added this cycle.
    always_comb begin
        part = psum_q;
        for (int k = 0; k < R; k++) begin
            if (mplier_q[k]) begin
                part = part + (mcand_q << k);
            end
        end
    end

    assign last   = run_q && (step_q == M_LAST);
    assign done_o = last;
    assign prod_o = neg_q ? (~part + 1'b1) : part;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q    <= 1'b0;
            step_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            psum_q   <= '0;
            neg_q    <= 1'b0;
        end else if (!run_q) begin
            if (start_i) begin
                run_q    <= 1'b1;
                step_q   <= '0;
                mcand_q  <= {{D_W{1'b0}}, a_mag};
                mplier_q <= b_mag;
                psum_q   <= '0;
                neg_q    <= a_neg ^ b_neg;
            end
        end else begin
            psum_q   <= part;
            mcand_q  <= mcand_q << R;
            mplier_q <= mplier_q >> R;
            step_q   <= last ? '0 : step_q + 1'b1;
            run_q    <= !last;
        end
    end

endmodule

// File: rtl/pe_v3.sv
// Processing element: sequential MAC with operand forwarding and an accumulator drain chain.
// Latency: operands/in_en forwarded 1 cycle; accumulator updated M = D_W/R cycles after acceptance.
// Backpressure: none; in_en while busy is dropped and flags err, drain chain never stalls.
// Ports: clk, rst (async active-low); init/in_en/in_a/in_b -> out_a/out_b/out_en;
//        in_data/in_valid -> out_data/out_valid (upstream wins over local reserve); busy; err (sticky).
module pe_v3
    import pe_pkg::*;
#(
    parameter int D_W      = 8,
    parameter int ACC_W    = 2 * D_W,
    parameter int R        = 2,
    parameter int SIGNED   = 0,
    parameter int SATURATE = 0,
    parameter int I        = 1,
    parameter int J        = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic             in_en,
    input  logic [D_W-1:0]   in_a,
    input  logic [D_W-1:0]   in_b,
    output logic [D_W-1:0]   out_a,
    output logic [D_W-1:0]   out_b,
    output logic             out_en,
    input  logic [ACC_W-1:0] in_data,
    input  logic             in_valid,
    output logic [ACC_W-1:0] out_data,
    output logic             out_valid,
    output logic             busy,
    output logic             err
);
    localparam int M     = pe_calc_m(D_W, R);
    localparam int P_W   = 2 * D_W;
    localparam int EXT_W = ACC_W + 1;
    localparam int CNT_W = (M > 1) ? $clog2(M) : 1;
    localparam logic [CNT_W-1:0] M_LAST = CNT_W'(M - 1);
    localparam logic SGN = (SIGNED != 0);
    localparam logic SAT = (SATURATE != 0);
    localparam logic [LIM_W-1:0] HI_W = pe_sat_hi(ACC_W, SGN);
    localparam logic [LIM_W-1:0] LO_W = pe_sat_lo(ACC_W, SGN);
    localparam logic [ACC_W-1:0] SAT_HI = HI_W[ACC_W-1:0];
    localparam logic [ACC_W-1:0] SAT_LO = LO_W[ACC_W-1:0];

    if (ACC_W < 2 * D_W) begin : g_chk_acc
        $error("pe_v3: ACC_W must be >= 2*D_W");
    end
    if (I < 0 || J < 0) begin : g_chk_coord
        $error("pe_v3: array coordinates must be non-negative");
    end

    pe_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             init_q, drop_q;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             acc_live_q, acc_live_d;
    logic [ACC_W-1:0] res_q, res_d;
    logic             res_full_q, res_full_d;
    logic             err_q;
    logic [D_W-1:0]   out_a_q, out_b_q;
    logic             out_en_q;
    logic [ACC_W-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;

    logic             accept, need_res, res_load, res_clash, busy_hit;
    logic             mul_done;
    logic [P_W-1:0]   mul_prod;
    logic [EXT_W-1:0] prod_x, base_x, sum_x;
    logic [ACC_W-1:0] acc_next;

    assign accept    = (state_q == ST_IDLE) && in_en;
    assign busy_hit  = (state_q == ST_MUL) && in_en;
    // A new tile's first pair evicts the previous tile's result into the reserve.
    assign need_res  = accept && init && acc_live_q;
    assign res_load  = need_res && !res_full_q;
    assign res_clash = need_res && res_full_q;

    pe_shift_add_mul_seq #(
        .D_W   (D_W),
        .R     (R),
        .SIGNED(SIGNED)
    ) u_mul (
        .clk    (clk),
        .rst    (rst),
        .start_i(accept),
        .a_i    (in_a),
        .b_i    (in_b),
        .done_o (mul_done),
        .prod_o (mul_prod)
    );

    // FSM: state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM: next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_en) begin
                    state_d = ST_MUL;
                    cnt_d   = '0;
                end
            end
            ST_MUL: begin
                if (cnt_q == M_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // One extra bit of headroom exposes overflow for the saturation decision.
    always_comb begin
        prod_x   = {{(EXT_W - P_W){SGN & mul_prod[P_W-1]}}, mul_prod};
        base_x   = init_q ? '0 : {SGN & acc_q[ACC_W-1], acc_q};
        sum_x    = base_x + prod_x;
        acc_next = sum_x[ACC_W-1:0];
        if (SAT) begin
            if (SGN) begin
                if (sum_x[EXT_W-1] != sum_x[EXT_W-2]) begin
                    acc_next = sum_x[EXT_W-1] ? SAT_LO : SAT_HI;
                end
            end else if (sum_x[EXT_W-1]) begin
                acc_next = SAT_HI;
            end
        end
    end

    always_comb begin
        acc_d      = acc_q;
        acc_live_d = acc_live_q;
        if (mul_done && !drop_q) begin
            acc_d      = acc_next;
            acc_live_d = 1'b1;
        end
    end

    // Drain chain: upstream traffic first, then the local reserve.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        res_d       = res_q;
        res_full_d  = res_full_q;
        if (in_valid) begin
            out_data_d  = in_data;
            out_valid_d = 1'b1;
        end else if (res_full_q) begin
            out_data_d  = res_q;
            out_valid_d = 1'b1;
            res_full_d  = 1'b0;
        end
        if (res_load) begin
            res_d      = acc_q;
            res_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            init_q      <= 1'b0;
            drop_q      <= 1'b0;
            acc_q       <= '0;
            acc_live_q  <= 1'b0;
            res_q       <= '0;
            res_full_q  <= 1'b0;
            err_q       <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_en_q    <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                init_q <= init;
                drop_q <= res_clash;
            end
            acc_q       <= acc_d;
            acc_live_q  <= acc_live_d;
            res_q       <= res_d;
            res_full_q  <= res_full_d;
            err_q       <= err_q | busy_hit | res_clash;
            out_a_q     <= in_a;
            out_b_q     <= in_b;
            out_en_q    <= in_en;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign out_en    = out_en_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == ST_MUL);
    assign err       = err_q;

endmodule

// File: tb/tb_pe_v3.sv
// Bench for pe_v3: four parameter variants share one randomized stimulus stream.
// Latency: n/a.  Backpressure: n/a.
module tb_pe_v3;
    localparam int N = 4;

    logic        clk;
    logic        rst;
    logic        t_init, t_en, t_iv;
    logic [7:0]  t_a, t_b;
    logic [15:0] t_id;

    logic [7:0]  oa [N];
    logic [7:0]  ob [N];
    logic        oe [N];
    logic [15:0] od [N];
    logic        ov [N];
    logic        bsy[N];
    logic        er [N];

    pe_v3 #(.D_W(8), .ACC_W(16), .R(2), .SIGNED(0), .SATURATE(0)) u_uw (
        .clk(clk), .rst(rst), .init(t_init), .in_en(t_en), .in_a(t_a), .in_b(t_b),
        .out_a(oa[0]), .out_b(ob[0]), .out_en(oe[0]), .in_data(t_id), .in_valid(t_iv),
        .out_data(od[0]), .out_valid(ov[0]), .busy(bsy[0]), .err(er[0]));
    pe_v3 #(.D_W(8), .ACC_W(16), .R(2), .SIGNED(1), .SATURATE(0)) u_sw (
        .clk(clk), .rst(rst), .init(t_init), .in_en(t_en), .in_a(t_a), .in_b(t_b),
        .out_a(oa[1]), .out_b(ob[1]), .out_en(oe[1]), .in_data(t_id), .in_valid(t_iv),
        .out_data(od[1]), .out_valid(ov[1]), .busy(bsy[1]), .err(er[1]));
    pe_v3 #(.D_W(8), .ACC_W(16), .R(2), .SIGNED(0), .SATURATE(1)) u_us (
        .clk(clk), .rst(rst), .init(t_init), .in_en(t_en), .in_a(t_a), .in_b(t_b),
        .out_a(oa[2]), .out_b(ob[2]), .out_en(oe[2]), .in_data(t_id), .in_valid(t_iv),
        .out_data(od[2]), .out_valid(ov[2]), .busy(bsy[2]), .err(er[2]));
    pe_v3 #(.D_W(8), .ACC_W(16), .R(4), .SIGNED(1), .SATURATE(1)) u_ss (
        .clk(clk), .rst(rst), .init(t_init), .in_en(t_en), .in_a(t_a), .in_b(t_b),
        .out_a(oa[3]), .out_b(ob[3]), .out_en(oe[3]), .in_data(t_id), .in_valid(t_iv),
        .out_data(od[3]), .out_valid(ov[3]), .busy(bsy[3]), .err(er[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference model: per-variant configuration and architectural state.
    bit     cf_sgn[N] = '{1'b0, 1'b1, 1'b0, 1'b1};
    bit     cf_sat[N] = '{1'b0, 1'b0, 1'b1, 1'b1};
    int     cf_m  [N] = '{4, 4, 4, 2};
    int     m_left[N];
    longint m_acc [N], m_res[N], m_prod[N];
    bit     m_pinit[N], m_drop[N], m_live[N], m_rfull[N], m_err[N], m_ov[N];
    logic [15:0] m_od[N];
    logic [7:0]  m_fa, m_fb;
    logic        m_fe;

    function automatic longint fit(input int k, input longint s);
        longint w;
        if (!cf_sgn[k]) begin
            if (cf_sat[k]) return (s > 65535) ? 65535 : s;
            return s % 65536;
        end
        if (cf_sat[k]) begin
            if (s > 32767) return 32767;
            if (s < -32768) return -32768;
            return s;
        end
        w = ((s % 65536) + 65536) % 65536;
        return (w >= 32768) ? w - 65536 : w;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_left[k] = 0; m_acc[k] = 0; m_res[k] = 0; m_prod[k] = 0;
            m_pinit[k] = 0; m_drop[k] = 0; m_live[k] = 0; m_rfull[k] = 0;
            m_err[k] = 0; m_ov[k] = 0; m_od[k] = '0;
        end
        m_fa = '0; m_fb = '0; m_fe = 1'b0;
    endtask

    task automatic model_step(input int k);
        bit     rf;
        longint pa, pb;
        rf = m_rfull[k];
        if (t_iv) begin
            m_od[k] = t_id; m_ov[k] = 1;
        end else if (rf) begin
            m_od[k] = 16'(m_res[k]); m_ov[k] = 1; m_rfull[k] = 0;
        end else begin
            m_ov[k] = 0;
        end
        if (m_left[k] > 0) begin
            if (t_en) m_err[k] = 1;
            m_left[k]--;
            if (m_left[k] == 0 && !m_drop[k]) begin
                m_acc[k]  = fit(k, (m_pinit[k] ? 0 : m_acc[k]) + m_prod[k]);
                m_live[k] = 1;
            end
        end else if (t_en) begin
            pa = cf_sgn[k] ? longint'($signed(t_a)) : longint'(t_a);
            pb = cf_sgn[k] ? longint'($signed(t_b)) : longint'(t_b);
            m_prod[k]  = pa * pb;
            m_pinit[k] = t_init;
            m_drop[k]  = 0;
            m_left[k]  = cf_m[k];
            if (t_init && m_live[k]) begin
                if (rf) begin
                    m_drop[k] = 1; m_err[k] = 1;
                end else begin
                    m_res[k] = m_acc[k]; m_rfull[k] = 1;
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < N; k++) begin
            chk($sformatf("u%0d.out_a", k), oa[k], m_fa);
            chk($sformatf("u%0d.out_b", k), ob[k], m_fb);
            chk($sformatf("u%0d.out_en", k), oe[k], m_fe);
            chk($sformatf("u%0d.busy", k), bsy[k], m_left[k] > 0);
            chk($sformatf("u%0d.err", k), er[k], m_err[k]);
            chk($sformatf("u%0d.out_valid", k), ov[k], m_ov[k]);
            chk($sformatf("u%0d.out_data", k), od[k], m_od[k]);
        end
    endtask

    task automatic check_zero(input string tag);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("%s u%0d outputs", tag, k),
                {oa[k], ob[k], oe[k], od[k], ov[k], bsy[k], er[k]}, 64'd0);
        end
    endtask

    task automatic step(input bit en, input bit ini, input logic [7:0] a, input logic [7:0] b,
                        input bit v, input logic [15:0] d);
        t_en = en; t_init = ini; t_a = a; t_b = b; t_iv = v; t_id = d;
        @(posedge clk);
        for (int k = 0; k < N; k++) model_step(k);
        m_fa = a; m_fb = b; m_fe = en;
        #1;
        compare_all();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 16'h0000);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bsy[0] === 1'b1 && n < 20) begin
            idle();
            n++;
        end
        chk("wait_idle", bsy[0], 1'b0);
    endtask

    logic [15:0] seq[4];
    int          nb1, nb3;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; t_en = 0; t_init = 0; t_iv = 0; t_a = '0; t_b = '0; t_id = '0;
        model_reset();
        #2;
        check_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset_held");
        @(negedge clk);
        rst = 1'b1;

        // Tile result 15 then 215; next init evicts 215 for exactly one cycle.
        step(1, 1, 8'd3, 8'd5, 0, 16'h0);
        wait_idle();
        step(1, 0, 8'd10, 8'd20, 0, 16'h0);
        wait_idle();
        step(1, 1, 8'd0, 8'd0, 0, 16'h0);
        idle();
        chk("drain_215_valid", ov[0], 1'b1);
        chk("drain_215_data", od[0], 16'd215);
        idle();
        chk("drain_one_cycle", ov[0], 1'b0);
        wait_idle();

        // Upstream traffic has priority; the reserve follows with no gap.
        step(1, 0, 8'd10, 8'd20, 0, 16'h0);
        wait_idle();
        step(1, 0, 8'd3, 8'd5, 0, 16'h0);
        wait_idle();
        seq[0] = 16'h0001; seq[1] = 16'h0002; seq[2] = 16'h0003; seq[3] = 16'h00D7;
        for (int k = 0; k < 4; k++) begin
            step(k == 0, k == 0, 8'd0, 8'd0, k < 3, (k < 3) ? seq[k] : 16'h0);
            chk("chain_valid", ov[0], 1'b1);
            chk("chain_data", od[0], seq[k]);
        end
        wait_idle();

        // Signed -3*7 = -21; busy lasts M cycles per variant.
        step(1, 1, 8'hFD, 8'd7, 0, 16'h0);
        nb1 = 0; nb3 = 0;
        while (bsy[1] === 1'b1 && nb1 < 20) begin
            nb1++;
            if (bsy[3] === 1'b1) nb3++;
            idle();
        end
        chk("signed_busy_cycles", nb1, 4);
        chk("r4_busy_cycles", nb3, 2);
        step(1, 1, 8'd0, 8'd0, 0, 16'h0);
        idle();
        chk("signed_acc_valid", ov[1], 1'b1);
        chk("signed_acc", od[1], 16'hFFEB);
        wait_idle();

        // 255*255 twice: wraps to 0xFC02, saturates to 0xFFFF.
        step(1, 1, 8'd255, 8'd255, 0, 16'h0);
        wait_idle();
        step(1, 0, 8'd255, 8'd255, 0, 16'h0);
        wait_idle();
        step(1, 1, 8'd0, 8'd0, 0, 16'h0);
        idle();
        chk("wrap_acc", od[0], 16'hFC02);
        chk("sat_acc", od[2], 16'hFFFF);
        wait_idle();

        // in_en while busy: forwarded, not multiplied, err raised.
        step(1, 0, 8'd9, 8'd9, 0, 16'h0);
        step(1, 0, 8'h5A, 8'h11, 0, 16'h0);
        chk("busy_hit_err", er[0], 1'b1);
        chk("busy_hit_fwd", oa[0], 8'h5A);
        wait_idle();
        step(1, 1, 8'd0, 8'd0, 0, 16'h0);
        idle();
        chk("busy_hit_acc", od[0], 16'd81);
        wait_idle();

        // Asynchronous reset in MUL cycle 2.
        step(1, 0, 8'd1, 8'd1, 0, 16'h0);
        idle();
        idle();
        rst = 1'b0;
        #1;
        check_zero("mid_mul_reset");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        step(1, 1, 8'd2, 8'd3, 0, 16'h0);
        chk("first_accept_after_reset", bsy[0], 1'b1);

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            step($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 30,
                 8'($urandom), 8'($urandom),
                 $urandom_range(0, 99) < 40, 16'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
